// File: rtl/knight_pkg.sv
// Shared types and constants for the remote command link.
package knight_pkg;

    localparam int         BAUD_DIV_50M_19200 = 2604;
    localparam logic [7:0] POS_ACK            = 8'hA5;

    typedef enum logic {WAIT_HI, WAIT_LO} wrap_state_t;
    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

endpackage

// File: rtl/uart_cmd_wrapper_uart.sv
// Full-duplex 8N1 UART: independent RX and TX engines.
module uart
    import knight_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_50M_19200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    output logic [7:0] rx_data,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done
);

    localparam int            CW      = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    logic          r_rx_ff1;
    logic          r_rx_ff2;
    logic          r_rx_prev;
    rx_state_t     r_rx_state;
    logic [CW-1:0] r_rx_baud;
    logic [3:0]    r_rx_bit;
    logic          r_rx_first;
    logic [7:0]    r_rx_shift;
    logic          r_rx_rdy;

    logic          w_rx_fall;
    logic [CW-1:0] w_rx_target;
    logic          w_rx_tick;

    tx_state_t     r_tx_state;
    logic [8:0]    r_tx_shift;
    logic [CW-1:0] r_tx_baud;
    logic [3:0]    r_tx_bit;
    logic          r_tx_done;

    logic          w_tx_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ff1  <= 1'b1;
            r_rx_ff2  <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_ff1  <= RX;
            r_rx_ff2  <= r_rx_ff1;
            r_rx_prev <= r_rx_ff2;
        end
    end

    assign w_rx_fall   = r_rx_prev & ~r_rx_ff2;
    assign w_rx_target = r_rx_first ? HALF_M1 : FULL_M1;
    assign w_rx_tick   = (r_rx_baud == w_rx_target);

    // Edge-detect cycle counts as the first clock of the half-bit wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_first <= 1'b0;
            r_rx_shift <= '0;
            r_rx_rdy   <= 1'b0;
        end else begin
            if (clr_rx_rdy) begin
                r_rx_rdy <= 1'b0;
            end
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= RX_RECV;
                        r_rx_baud  <= CW'(1);
                        r_rx_bit   <= '0;
                        r_rx_first <= 1'b1;
                        r_rx_rdy   <= 1'b0;
                    end
                end
                RX_RECV: begin
                    if (w_rx_tick) begin
                        r_rx_baud  <= '0;
                        r_rx_first <= 1'b0;
                        r_rx_bit   <= r_rx_bit + 4'd1;
                        if (r_rx_bit != 4'd0 && r_rx_bit != 4'd9) begin
                            r_rx_shift <= {r_rx_ff2, r_rx_shift[7:1]};
                        end
                        if (r_rx_bit == 4'd9) begin
                            r_rx_state <= RX_IDLE;
                            r_rx_rdy   <= 1'b1;
                        end
                    end else begin
                        r_rx_baud <= r_rx_baud + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_rdy  = r_rx_rdy;
    assign rx_data = r_rx_shift;

    assign w_tx_tick = (r_tx_baud == FULL_M1);

    // TX is the LSB of the shifter; ones shifted in form the stop bit and idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '1;
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx_done  <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (trmt) begin
                        r_tx_state <= TX_BUSY;
                        r_tx_shift <= {tx_data, 1'b0};
                        r_tx_baud  <= '0;
                        r_tx_bit   <= '0;
                        r_tx_done  <= 1'b0;
                    end
                end
                TX_BUSY: begin
                    if (w_tx_tick) begin
                        r_tx_baud  <= '0;
                        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                        if (r_tx_bit == 4'd9) begin
                            r_tx_state <= TX_IDLE;
                            r_tx_done  <= 1'b1;
                        end else begin
                            r_tx_bit <= r_tx_bit + 4'd1;
                        end
                    end else begin
                        r_tx_baud <= r_tx_baud + 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign TX      = r_tx_shift[0];
    assign tx_done = r_tx_done;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Robot-side command endpoint: two RX bytes form a 16-bit command,
// one response byte goes back over TX.
module uart_cmd_wrapper
    import knight_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_50M_19200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    logic        w_rx_rdy;
    logic [7:0]  w_rx_data;

    wrap_state_t r_state;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;

    uart #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .rx_rdy     (w_rx_rdy),
        .clr_rx_rdy (w_rx_rdy),
        .rx_data    (w_rx_data),
        .trmt       (trmt),
        .tx_data    (resp),
        .tx_done    (tx_done)
    );

    // A byte arrival takes priority over the consumer acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= WAIT_HI;
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
        end else if (w_rx_rdy) begin
            case (r_state)
                WAIT_HI: begin
                    r_cmd[15:8] <= w_rx_data;
                    r_cmd_rdy   <= 1'b0;
                    r_state     <= WAIT_LO;
                end
                WAIT_LO: begin
                    r_cmd[7:0] <= w_rx_data;
                    r_cmd_rdy  <= 1'b1;
                    r_state    <= WAIT_HI;
                end
                default: r_state <= WAIT_HI;
            endcase
        end else if (clr_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
        end
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper with BAUD_DIV=16.
module tb_uart_cmd_wrapper;
    import knight_pkg::*;

    localparam int BAUD  = 16;
    localparam int FRAME = 10 * BAUD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        trmt = 1'b0;
    logic        tx_done;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    // Behavioural model state
    int          m_age = -1;
    bit          m_pend = 1'b0;
    logic [7:0]  m_byte = 8'h00;
    logic [15:0] m_cmd = 16'h0000;
    bit          m_rdy = 1'b0;
    bit          m_hi = 1'b1;
    bit          m_rx_busy = 1'b0;
    bit          m_rx_evt = 1'b0;
    logic [7:0]  m_rx_byte = 8'h00;

    always #5 clk = ~clk;

    uart_cmd_wrapper #(
        .BAUD_DIV (BAUD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_rng(input string nm, input int act,
                             input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Model: TX frame as a function of clocks since the accepted trmt,
    // cmd/cmd_rdy updated per received byte and on acknowledge.
    initial begin : cmp
        logic [9:0] fr;
        wait (chk_on);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_TX", TX, 1);
                check("rst_tx_done", tx_done, 0);
                check("rst_cmd", cmd, 0);
                check("rst_cmd_rdy", cmd_rdy, 0);
                m_age    = -1;
                m_pend   = 1'b0;
                m_cmd    = 16'h0000;
                m_rdy    = 1'b0;
                m_hi     = 1'b1;
                m_rx_evt = 1'b0;
            end else begin
                if (m_pend) begin
                    m_age  = 0;
                    m_pend = 1'b0;
                end else if (m_age >= 0) begin
                    m_age++;
                end
                if (m_rx_evt) begin
                    m_rx_evt = 1'b0;
                    if (m_hi) begin
                        m_cmd[15:8] = m_rx_byte;
                        m_rdy = 1'b0;
                    end else begin
                        m_cmd[7:0] = m_rx_byte;
                        m_rdy = 1'b1;
                    end
                    m_hi = !m_hi;
                end
                fr = {1'b1, m_byte, 1'b0};
                check("m_TX", TX,
                      (m_age >= 0 && m_age < FRAME) ? fr[m_age / BAUD] : 1'b1);
                check("m_tx_done", tx_done, (m_age >= FRAME) ? 1 : 0);
                if (!m_rx_busy) begin
                    check("m_cmd", cmd, m_cmd);
                    check("m_cmd_rdy", cmd_rdy, m_rdy);
                    if (clr_cmd_rdy) m_rdy = 1'b0;
                end
                if (trmt && !m_pend && !(m_age >= 0 && m_age < FRAME)) begin
                    m_pend = 1'b1;
                    m_byte = resp;
                end
            end
        end
    end

    // rise_n: clocks into the stop bit at which cmd_rdy is first seen high
    task automatic send_byte(input logic [7:0] b, output int rise_n);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        rise_n = -1;
        m_rx_busy = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            RX = fr[i];
            for (int n = 1; n <= BAUD; n++) begin
                @(posedge clk); #1;
                if (i == 9 && rise_n < 0 && cmd_rdy === 1'b1) rise_n = n;
            end
        end
        m_rx_byte = b;
        m_rx_evt  = 1'b1;
        m_rx_busy = 1'b0;
    endtask

    task automatic send_cmd(input logic [15:0] c);
        int d;
        int r;
        send_byte(c[15:8], d);
        send_byte(c[7:0], r);
        check_rng("rdy_rise", r, 9, 11);
        @(negedge clk);
        check("cmd_val", cmd, c);
        check("cmd_rdy_set", cmd_rdy, 1);
    endtask

    task automatic tx_byte(input logic [7:0] b, input bit poke,
                           output int n, output logic [9:0] bits);
        bits = '0;
        @(posedge clk); #1;
        resp = b;
        trmt = 1'b1;
        @(posedge clk); #1;
        trmt = 1'b0;
        n = 1;
        while (tx_done !== 1'b1 && n < 4 * FRAME) begin
            if (n >= 9 && (n - 9) % BAUD == 0 && (n - 9) / BAUD < 10)
                bits[(n - 9) / BAUD] = TX;
            if (poke && n == 50) begin
                resp = 8'h00;
                trmt = 1'b1;
            end else begin
                trmt = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        trmt = 1'b0;
    endtask

    initial begin : stim
        int n;
        int r;
        int lows;
        logic [9:0] bits;

        #2 rst_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("reset_TX", TX, 1);
        check("reset_cmd", cmd, 16'h0000);
        check("reset_cmd_rdy", cmd_rdy, 0);
        check("reset_tx_done", tx_done, 0);
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (TX !== 1'b1) lows++;
        end
        check("tx_idle_1000", lows, 0);

        send_cmd(16'h4001);
        @(posedge clk); #1 clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 clr_cmd_rdy = 1'b0;
        @(negedge clk);
        check("ack_clears", cmd_rdy, 0);
        check("ack_keeps_cmd", cmd, 16'h4001);

        send_cmd(16'h43F1);
        send_byte(8'h47, r);
        @(negedge clk);
        check("b2b_rdy_drop", cmd_rdy, 0);
        check("b2b_hi", cmd[15:8], 8'h47);
        send_byte(8'hF1, r);
        check_rng("b2b_rise", r, 9, 11);
        @(negedge clk);
        check("b2b_cmd", cmd, 16'h47F1);
        check("b2b_rdy", cmd_rdy, 1);

        tx_byte(8'hA5, 1'b1, n, bits);
        check("tx_a5_done_lat", n, 161);
        check("tx_a5_bits", bits, 10'h34A);
        repeat (5) @(negedge clk);
        check("tx_done_hold", tx_done, 1);
        tx_byte(8'h3C, 1'b0, n, bits);
        check("tx_3c_done_lat", n, 161);
        check("tx_3c_bits", bits, 10'h278);

        send_byte(8'h2A, r);
        @(negedge clk);
        check("part_hi", cmd[15:8], 8'h2A);
        m_rx_busy = 1'b1;
        @(posedge clk); #1 RX = 1'b0;
        repeat (BAUD) @(posedge clk);
        #1 RX = 1'b1;
        repeat (BAUD) @(posedge clk);
        #1 RX = 1'b0;
        repeat (BAUD) @(posedge clk);
        #3 rst_n = 1'b0;
        RX = 1'b1;
        m_rx_busy = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rst_mid_cmd", cmd, 16'h0000);
        send_cmd(16'h2000);

        fork
            send_cmd(16'hBEEF);
            tx_byte(POS_ACK, 1'b0, n, bits);
        join
        check("fdx_done_lat", n, 161);
        check("fdx_bits", bits, 10'h34A);

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
